// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice: default widths,
// the hard-wired zero register index and the requester-ID encoding.
package wb_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int AW_DEFAULT   = 5;
    localparam int ZERO_REG     = 0;

    typedef enum logic {
        REQ_P = 1'b0,
        REQ_M = 1'b1
    } req_id_e;

    function automatic req_id_e other_req(input req_id_e r);
        return (r == REQ_P) ? REQ_M : REQ_P;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Load scoreboard: tracks registers with an outstanding load and flags
// protocol errors (double issue, completion to a register never issued).
module wb_scoreboard
    import wb_arbiter_pkg::*;
#(
    parameter int AW   = AW_DEFAULT,
    parameter int NREG = 2**AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy_mask,
    output logic            sb_err
);

    logic [NREG-1:0] busy_d, busy_q;
    logic            err_d, err_q;
    logic            set_valid;
    logic            clr_nonzero;

    // Next busy mask and sticky error; a set applied after the clear so set wins
    always_comb begin
        busy_d      = busy_q;
        err_d       = err_q;
        set_valid   = set_en && (set_addr != AW'(ZERO_REG));
        clr_nonzero = clr_en && (clr_addr != AW'(ZERO_REG));
        if (set_valid && busy_q[set_addr]) begin
            err_d = 1'b1;
        end
        if (clr_nonzero && !busy_q[clr_addr]) begin
            err_d = 1'b1;
        end
        if (clr_nonzero) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_valid) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    // Scoreboard state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask = busy_q;
    assign sb_err    = err_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: two requesters (pipeline P, load unit M)
// share one write port through a 1-bit round-robin and a registered output
// stage. Optional macro WB_ARBITER_BYPASS_EN adds read-port forwarding of the
// registered write.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int NREG = 2**AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            p_valid,
    output logic            p_ready,
    input  logic [AW-1:0]   p_addr,
    input  logic [XLEN-1:0] p_data,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic [AW-1:0]   m_addr,
    input  logic [XLEN-1:0] m_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_addr,
    output logic            write_en,
    output logic [AW-1:0]   write_addr,
    output logic [XLEN-1:0] write_value,
    output logic [NREG-1:0] busy_mask,
`ifdef WB_ARBITER_BYPASS_EN
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [XLEN-1:0] rs1_reg,
    input  logic [XLEN-1:0] rs2_reg,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
`endif
    output logic            sb_err
);

    req_id_e         rr_d, rr_q;
    logic            p_grant, m_grant;
    logic            p_acc, m_acc;
    logic            write_en_d, write_en_q;
    logic [AW-1:0]   write_addr_d, write_addr_q;
    logic [XLEN-1:0] write_value_d, write_value_q;

    // Grant offer: a requester is offered the port unless the other one is
    // valid and holds round-robin priority, so ready never looks at its own
    // valid. The RR bit only moves on a real conflict.
    always_comb begin
        p_grant = 1'b0;
        m_grant = 1'b0;
        rr_d    = rr_q;
        if (!reset) begin
            p_grant = !m_valid || (rr_q == REQ_P);
            m_grant = !p_valid || (rr_q == REQ_M);
            if (p_valid && m_valid) begin
                rr_d = other_req(rr_q);
            end
        end
        p_acc = p_valid && p_grant;
        m_acc = m_valid && m_grant;
    end

    // Output stage next state: an accepted transfer is written one cycle
    // later, except to x0 which is consumed without a write
    always_comb begin
        write_en_d    = 1'b0;
        write_addr_d  = write_addr_q;
        write_value_d = write_value_q;
        if (p_acc && (p_addr != AW'(ZERO_REG))) begin
            write_en_d    = 1'b1;
            write_addr_d  = p_addr;
            write_value_d = p_data;
        end else if (m_acc && (m_addr != AW'(ZERO_REG))) begin
            write_en_d    = 1'b1;
            write_addr_d  = m_addr;
            write_value_d = m_data;
        end
    end

    // Arbiter and output-stage registers; reset discards any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q          <= REQ_M;
            write_en_q    <= 1'b0;
            write_addr_q  <= '0;
            write_value_q <= '0;
        end else begin
            rr_q          <= rr_d;
            write_en_q    <= write_en_d;
            write_addr_q  <= write_addr_d;
            write_value_q <= write_value_d;
        end
    end

    assign p_ready     = p_grant;
    assign m_ready     = m_grant;
    assign write_en    = write_en_q;
    assign write_addr  = write_addr_q;
    assign write_value = write_value_q;

    wb_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (ld_issue),
        .set_addr  (ld_issue_addr),
        .clr_en    (m_acc),
        .clr_addr  (m_addr),
        .busy_mask (busy_mask),
        .sb_err    (sb_err)
    );

`ifdef WB_ARBITER_BYPASS_EN
    // Forward the registered write to the read ports; x0 is never forwarded
    always_comb begin
        rs1_data = rs1_reg;
        rs2_data = rs2_reg;
        if (write_en_q && (write_addr_q == rs1_addr) && (rs1_addr != AW'(ZERO_REG))) begin
            rs1_data = write_value_q;
        end
        if (write_en_q && (write_addr_q == rs2_addr) && (rs2_addr != AW'(ZERO_REG))) begin
            rs2_data = write_value_q;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a small reference model predicts
// grants, scoreboard state and the write expected one cycle after each
// accepted transfer; expected writes go through a queue.
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    logic            clk;
    logic            reset;
    logic            p_valid, m_valid, p_ready, m_ready;
    logic [AW-1:0]   p_addr, m_addr, ld_issue_addr, write_addr;
    logic [XLEN-1:0] p_data, m_data, write_value;
    logic            ld_issue, write_en, sb_err;
    logic [NREG-1:0] busy_mask;
`ifdef WB_ARBITER_BYPASS_EN
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_reg, rs2_reg, rs1_data, rs2_data;
`endif

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;
    } exp_write_t;

    exp_write_t      expQ[$];
    logic            rrFavourM;
    logic [NREG-1:0] expBusy;
    logic            expErr;
    int              checkCount;
    int              passCount;

    wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .p_valid       (p_valid),
        .p_ready       (p_ready),
        .p_addr        (p_addr),
        .p_data        (p_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_addr        (m_addr),
        .m_data        (m_data),
        .ld_issue      (ld_issue),
        .ld_issue_addr (ld_issue_addr),
        .write_en      (write_en),
        .write_addr    (write_addr),
        .write_value   (write_value),
        .busy_mask     (busy_mask),
`ifdef WB_ARBITER_BYPASS_EN
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_reg       (rs1_reg),
        .rs2_reg       (rs2_reg),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
`endif
        .sb_err        (sb_err)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic driveIdle();
        p_valid = 1'b0; p_addr = '0; p_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        ld_issue = 1'b0; ld_issue_addr = '0;
    endtask

    // Reset with active-looking inputs; checks the held-in-reset state
    task automatic doReset();
        reset = 1'b1;
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h1111_1111;
        m_valid = 1'b1; m_addr = 5'd6; m_data = 32'h2222_2222;
        ld_issue = 1'b1; ld_issue_addr = 5'd9;
        @(posedge clk); #1;
        checkOutput("rst_write_en", 64'(write_en), 64'd0);
        checkOutput("rst_write_addr", 64'(write_addr), 64'd0);
        checkOutput("rst_write_value", 64'(write_value), 64'd0);
        checkOutput("rst_busy_mask", 64'(busy_mask), 64'd0);
        checkOutput("rst_sb_err", 64'(sb_err), 64'd0);
        checkOutput("rst_p_ready", 64'(p_ready), 64'd0);
        checkOutput("rst_m_ready", 64'(m_ready), 64'd0);
        @(posedge clk); #1;
        driveIdle();
        reset = 1'b0;
        rrFavourM = 1'b1;
        expBusy = '0;
        expErr = 1'b0;
        expQ.delete();
    endtask

    // One cycle: drive inputs, check readiness at the negedge, predict the
    // write and scoreboard, then compare after the rising edge
    task automatic applyStimulus(input logic pv, input logic [AW-1:0] pa, input logic [XLEN-1:0] pd,
                                 input logic mv, input logic [AW-1:0] ma, input logic [XLEN-1:0] md,
                                 input logic li, input logic [AW-1:0] la);
        logic expPr, expMr, pAcc, mAcc, setV, clrV;
        exp_write_t e;
        p_valid = pv; p_addr = pa; p_data = pd;
        m_valid = mv; m_addr = ma; m_data = md;
        ld_issue = li; ld_issue_addr = la;
        @(negedge clk);
        expPr = !mv || !rrFavourM;
        expMr = !pv || rrFavourM;
        checkOutput("p_ready", 64'(p_ready), 64'(expPr));
        checkOutput("m_ready", 64'(m_ready), 64'(expMr));
        pAcc = pv && expPr;
        mAcc = mv && expMr;
        e.we   = (pAcc && pa != 0) || (mAcc && ma != 0);
        e.addr = pAcc ? pa : ma;
        e.val  = pAcc ? pd : md;
        expQ.push_back(e);
        if (pv && mv) rrFavourM = !rrFavourM;
        setV = li && (la != 0);
        clrV = mAcc && (ma != 0);
        if (setV && expBusy[la]) expErr = 1'b1;
        if (clrV && !expBusy[ma]) expErr = 1'b1;
        if (clrV) expBusy[ma] = 1'b0;
        if (setV) expBusy[la] = 1'b1;
        @(posedge clk); #1;
        e = expQ.pop_front();
        checkOutput("write_en", 64'(write_en), 64'(e.we));
        if (e.we) begin
            checkOutput("write_addr", 64'(write_addr), 64'(e.addr));
            checkOutput("write_value", 64'(write_value), 64'(e.val));
        end
        checkOutput("busy_mask", 64'(busy_mask), 64'(expBusy));
        checkOutput("sb_err", 64'(sb_err), 64'(expErr));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset = 1'b1;
        driveIdle();
`ifdef WB_ARBITER_BYPASS_EN
        rs1_addr = '0; rs2_addr = '0; rs1_reg = '0; rs2_reg = '0;
`endif
        doReset();
        idleCycle();

        // Conflict from reset: grants alternate M,P,M,P with back-to-back writes
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'd2, 32'h200 + 32'(i), 1'b0, '0);
        end
        doReset();
        idleCycle();

        // Single P write, then write to x0 which must be suppressed
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0);
        applyStimulus(1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, '0, 1'b0, '0);
        idleCycle();

        // Load issue then completion to 7
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h7777_0007, 1'b0, '0);
        idleCycle();

        // P write to a busy register; ld_issue to x0 ignored
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd6);
        applyStimulus(1'b1, 5'd6, 32'h6666_6666, 1'b0, '0, '0, 1'b1, 5'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd6, 32'h0606_0606, 1'b0, '0);

        // Same-cycle completion and re-issue of register 4: set wins
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd4);
        doReset();

        // Double issue to 3 sets a sticky error cleared only by reset
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
        idleCycle();
        idleCycle();
        doReset();
        idleCycle();

        // Completion to an address that was never issued
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd12, 32'h0C0C_0C0C, 1'b0, '0);
        doReset();

`ifdef WB_ARBITER_BYPASS_EN
        // Forwarding of the registered write to the read ports
        applyStimulus(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, '0, '0, 1'b0, '0);
        rs1_addr = 5'd9; rs1_reg = 32'h0;
        rs2_addr = 5'd0; rs2_reg = 32'h1234_5678;
        #1;
        checkOutput("rs1_data_fwd", 64'(rs1_data), 64'hA5A5_A5A5);
        checkOutput("rs2_data_x0", 64'(rs2_data), 64'h1234_5678);
        idleCycle();
        #1;
        checkOutput("rs1_data_nofwd", 64'(rs1_data), 64'h0);
        rs1_addr = '0; rs2_addr = '0; rs2_reg = '0;
`endif

        // Random mixed traffic
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 32'($urandom),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 32'($urandom),
                          1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of the register-file write port.
REQ-002 Parameter AW, default 5, register address width; NREG = 2**AW.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port p_valid/p_ready  in/out  1/1  pipeline (ALU/CSR/JAL) writeback handshake.
REQ-006 Port p_addr/p_data  in  AW/XLEN  pipeline writeback destination and value.
REQ-007 Port m_valid/m_ready  in/out  1/1  load-unit writeback handshake.
REQ-008 Port m_addr/m_data  in  AW/XLEN  load writeback destination and value.
REQ-009 Port ld_issue/ld_issue_addr  in  1/AW  load issued; marks its destination pending.
REQ-010 Port write_en/write_addr/write_value  out  1/AW/XLEN  register-file write port drive.
REQ-011 Port busy_mask  out  NREG  bit i = load to register i outstanding.
REQ-012 Port sb_err  out  1  sticky scoreboard protocol error.

Function
REQ-013 The block SHALL accept a transfer on a requester in the cycle its valid and ready are both high.
REQ-014 Ready SHALL be combinational and equal that requester's grant; never depends on its own valid.
REQ-015 Only P valid: P granted; only M valid: M granted; neither valid: no grant, RR state unchanged.
REQ-016 Both valid: grant the requester not granted on the last conflict (1-bit round-robin state); first conflict after reset grants M.
REQ-017 An accepted transfer SHALL appear on write_en/write_addr/write_value exactly one cycle later (registered output stage), write_en high for exactly one cycle.
REQ-018 An accepted transfer with addr 0 SHALL be consumed but drive write_en low (x0 never written).
REQ-019 Maximum throughput one write per cycle; back-to-back grants SHALL produce back-to-back write_en.
REQ-020 ld_issue with ld_issue_addr != 0 SHALL set busy_mask[addr] the next cycle; addr 0 ignored.
REQ-021 An accepted M transfer SHALL clear busy_mask[m_addr] the next cycle.
REQ-022 Same-cycle set and clear of the same bit: set wins.
REQ-023 ld_issue to an already-busy address, or accepted M transfer to a non-busy nonzero address, SHALL set sb_err; mask bit left set.
REQ-024 P transfer to a busy register SHALL be accepted and written; busy_mask unaffected.

Reset
REQ-025 While reset is high: write_en=0, write_addr=0, write_value=0, busy_mask=0, sb_err=0, RR state=favour M, p_ready=m_ready=0.
REQ-026 Reset asserted mid-transfer SHALL discard the registered write; no write_en in the cycle after reset deasserts.

Configuration
REQ-027 Macro WB_ARBITER_BYPASS_EN defined: add inputs rs1_addr, rs2_addr (AW), rs1_reg, rs2_reg (XLEN) and outputs rs1_data, rs2_data (XLEN).
REQ-028 With the macro: rsN_data = write_value when write_en and write_addr == rsN_addr and rsN_addr != 0, else rsN_reg (combinational).
REQ-029 Without the macro: those ports SHALL NOT exist and no comparator logic is built.

Structure
REQ-030 Shared package SHALL hold XLEN/AW defaults, the zero-register index constant and the requester-ID encoding (P=0, M=1).
REQ-031 One sub-module, wb_scoreboard, SHALL contain busy_mask and sb_err; arbiter and output stage stay in the top.

Verification
REQ-032 P only: p_addr=5, p_data=0xDEADBEEF -> p_ready same cycle; next cycle write_en=1, addr 5, value 0xDEADBEEF.
REQ-033 Both valid for 4 cycles from reset (P addr 1, M addr 2) -> grants M,P,M,P; four consecutive write_en pulses.
REQ-034 ld_issue addr 7; later M write addr 7 -> busy_mask[7]=1 after issue, 0 the cycle after the M acceptance; sb_err stays 0.
REQ-035 P write addr 0 value 0x1234 -> p_ready=1, write_en stays 0.
REQ-036 ld_issue addr 3 twice without completion -> sb_err=1 and held until reset; reset clears busy_mask and sb_err.
REQ-037 BYPASS_EN build: write_en to addr 9 value 0xA5A5A5A5 with rs1_addr=9, rs1_reg=0 -> rs1_data=0xA5A5A5A5; rs2_addr=0 -> rs2_data=rs2_reg.
